// File: rtl/serializador_vetores_pkg.sv
// Shared definitions for the word-to-byte serializer and its byte selector.
// Latency: none (constants and an elaboration-time helper only).
// Backpressure: not applicable.
package serializador_pkg;

   // FSM state encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Byte order select, sampled together with each word
   localparam logic ORD_LSB_FIRST = 1'b0;
   localparam logic ORD_MSB_FIRST = 1'b1;

   // Byte index width for an N-byte word. Held at a minimum of 1 bit so that a
   // degenerate single-byte configuration still has a legal index vector.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serializador_vetores_seletor_byte.sv
// Combinational N:1 byte mux: picks byte[index] or byte[N-1-index] of a word.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller holds word/index/ordem stable while stalled.
module seletor_byte
   import serializador_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BYTE_W = 8,
   localparam int N     = WIDTH / BYTE_W,
   localparam int IW    = idx_w(N)
) (
   input  logic [WIDTH-1:0]  word,
   input  logic [IW-1:0]     index,
   input  logic              ordem,
   output logic [BYTE_W-1:0] out_byte
);

   logic [IW-1:0] sel;

   // Map the stream position onto a physical byte lane, then mux that lane out.
   // Lanes are compared one by one so that no out-of-range slice can be formed.
   always_comb begin
      sel      = (ordem == ORD_MSB_FIRST) ? (IW'(N - 1) - index) : index;
      out_byte = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == IW'(i)) begin
            out_byte = word[i*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/serializador_vetores.sv
// Serializes one WIDTH-bit word into N BYTE_W-bit beats, LSB- or MSB-first per word.
// Latency: word accepted at edge k, first byte valid in cycle k+1; one word per N cycles.
// Backpressure: out_ready low freezes byte/last/index; in_ready only in IDLE or last-beat transfer.
module serializador_vetores
   import serializador_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              ordem,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy
);

   localparam int N  = WIDTH / BYTE_W;
   localparam int IW = idx_w(N);

   logic [0:0]        state_q;
   logic [WIDTH-1:0]  word_q;
   logic [IW-1:0]     idx_q;
   logic              ordem_q;

   logic              is_send;
   logic              is_last;
   logic              accept;
   logic              xfer;
   logic [BYTE_W-1:0] sel_byte;

   assign is_send   = (state_q == ST_SEND);
   assign is_last   = is_send && (idx_q == IW'(N - 1));
   assign out_valid = is_send;
   assign out_last  = is_last;
   assign busy      = is_send;

   // The last-beat window lets the next word slip in on the same edge the final
   // byte leaves, which is what keeps back-to-back words bubble-free.
   assign in_ready  = !is_send || (is_last && out_ready);
   assign accept    = in_valid && in_ready;
   assign xfer      = is_send && out_ready;

   // Gate the mux in IDLE so a stale word never shows on the byte bus.
   assign out_byte  = is_send ? sel_byte : '0;

   seletor_byte #(
      .WIDTH  (WIDTH),
      .BYTE_W (BYTE_W)
   ) u_seletor (
      .word     (word_q),
      .index    (idx_q),
      .ordem    (ordem_q),
      .out_byte (sel_byte)
   );

   // FSM, word/order capture and byte index; reset drops any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         ordem_q <= ORD_LSB_FIRST;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  word_q  <= in_data;
                  ordem_q <= ordem;
                  idx_q   <= '0;
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  if (is_last) begin
                     idx_q <= '0;
                     if (accept) begin
                        word_q  <= in_data;
                        ordem_q <= ordem;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serializador_vetores.sv
// Scoreboard bench for serializador_vetores: directed words, queued expected bytes.
// Latency: checks first byte one cycle after acceptance and gapless back-to-back words.
// Backpressure: stalls out_ready mid-word and checks hold/ignore behaviour.
module tb_serializador_vetores;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        ordem;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;

   typedef struct {
      logic [7:0] b;
      logic       last;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   serializador_vetores #(.WIDTH(32), .BYTE_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ordem     (ordem),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Present a word and wait for the handshake; push its bytes when accepted.
   // After acceptance ordem is flipped and in_data scrambled to show they are not re-sampled.
   task automatic send_word(input logic [31:0] d, input logic o);
      int   t;
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      ordem    = o;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 50) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      for (int i = 0; i < 4; i++) begin
         e.b    = (o == 1'b0) ? d[i*8 +: 8] : d[(3-i)*8 +: 8];
         e.last = (i == 3);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      ordem    = ~o;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || busy) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: every valid beat must match the head of the scoreboard; a stalled
   // beat is peeked (must stay stable), a transferred beat is popped.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_byte", {24'd0, out_byte}, 32'hFFFF_FFFF);
         end else begin
            chk("out_byte", {24'd0, out_byte}, {24'd0, sb[0].b});
            chk("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
            if (out_ready) begin
               // in_ready rises during a transfer only on the final byte
               chk("in_ready_beat", {31'd0, in_ready}, {31'd0, sb[0].last});
               void'(sb.pop_front());
            end else begin
               chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      ordem     = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_out_byte",  {24'd0, out_byte},  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1: LSB-first, expect 78 56 34 12
      send_word(32'h1234_5678, 1'b0);
      @(negedge clk);
      chk("t1_first_beat_valid", {31'd0, out_valid}, 32'd1);
      drain();
      chk("t1_in_ready_after", {31'd0, in_ready}, 32'd1);

      // 2: MSB-first, expect 12 34 56 78; ordem flips after acceptance
      send_word(32'h1234_5678, 1'b1);
      drain();

      // 3: backpressure on BB (order DD CC BB AA)
      send_word(32'hAABB_CCDD, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t3_hold_byte",  {24'd0, out_byte},  32'h0000_00BB);
         chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();

      // 4: back-to-back, expect 04 03 02 01 08 07 06 05 with no idle cycle
      send_word(32'h0102_0304, 1'b0);
      fork
         send_word(32'h0506_0708, 1'b0);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               chk("t4_no_bubble", {31'd0, out_valid}, 32'd1);
            end
         end
      join
      drain();

      // 5: a word offered while busy is held off until the last-beat window
      send_word(32'hDEAD_BEEF, 1'b0);
      fork
         send_word(32'h1111_1111, 1'b0);
         begin
            @(negedge clk);
            @(negedge clk);
            chk("t5_busy_byte",     {24'd0, out_byte}, 32'h0000_00BE);
            chk("t5_busy_in_ready", {31'd0, in_ready}, 32'd0);
         end
      join
      drain();

      // 6: asynchronous reset after 0D has transferred
      send_word(32'hCAFE_F00D, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_out_last",  {31'd0, out_last},  32'd0);
      chk("t6_rst_busy",      {31'd0, busy},      32'd0);
      chk("t6_rst_out_byte",  {24'd0, out_byte},  32'd0);
      chk("t6_remaining_bytes", sb.size(), 3);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("t6_in_ready_after", {31'd0, in_ready},  32'd1);
      chk("t6_idle_after",     {31'd0, out_valid}, 32'd0);

      chk("sb_empty_end", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global guard so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

endmodule
